// File: rtl/oracle_trace_pkg.sv
// Shared definitions for the core-oracle event protocol.
//   ev_kind_e    : record kind encoding seen by the oracle sink
//   oracle_ev_t  : one serialized trace record (kind, id, pc, a, b, ts)
//   MAX_PUSH     : records that can enter the buffer in one cycle
//   sat_add_drop : saturating accumulator for the dropped-event count
package oracle_trace_pkg;

  localparam int unsigned MAX_PUSH    = 6;
  // The record carries a fixed-width id; the tracer's ID_W must match it.
  localparam int unsigned ORACLE_ID_W = 32;

  typedef enum logic [2:0] {
    EV_DECODE   = 3'd0,
    EV_ISSUE    = 3'd1,
    EV_WB       = 3'd2,
    EV_COMMIT   = 3'd3,
    EV_SQUASH   = 3'd4,
    EV_OVERFLOW = 3'd5
  } ev_kind_e;

  typedef struct packed {
    ev_kind_e                kind;
    logic [ORACLE_ID_W-1:0]  id;
    logic [63:0]             pc;
    logic [63:0]             a;
    logic [63:0]             b;
    logic [31:0]             ts;
  } oracle_ev_t;

  // Add the number of events lost this cycle, sticking at all-ones.
  function automatic logic [31:0] sat_add_drop(input logic [31:0] cnt,
                                               input logic [2:0]  n);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {30'd0, n};
    if (sum[32]) begin
      sat_add_drop = 32'hFFFF_FFFF;
    end else begin
      sat_add_drop = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/multi_push_fifo.sv
// Circular buffer accepting up to MAX_PUSH entries per cycle and popping one.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_data_i   : packed push vector, slot 0 is the oldest entry
//   push_cnt_i    : number of leading slots to write (caller guarantees room)
//   pop_i         : remove the head entry (ignored when empty)
//   head_o        : entry at the read pointer
//   empty_o/full_o: buffer state; occ_o: registered occupancy
module multi_push_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter type         T        = logic [7:0],
  parameter int unsigned MAX_PUSH = 6,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = $clog2(MAX_PUSH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  T [MAX_PUSH-1:0]     push_data_i,
  input  logic [CW-1:0]       push_cnt_i,
  input  logic                pop_i,
  output T                    head_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [AW:0]         occ_o
);

  T             mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         pop_en_s;

  assign empty_o  = (wptr_q == rptr_q);
  assign full_o   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign occ_o    = wptr_q - rptr_q;
  assign head_o   = mem_q[rptr_q[AW-1:0]];
  assign pop_en_s = pop_i && !empty_o;

  // Pointer advance for this cycle's pushes and pop.
  always_comb begin
    wptr_d = wptr_q + (AW+1)'(push_cnt_i);
    rptr_d = rptr_q + {{AW{1'b0}}, pop_en_s};
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage: write the leading push_cnt_i slots at consecutive addresses.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_PUSH; i++) begin
      if (i < int'(push_cnt_i)) begin
        mem_q[wptr_q[AW-1:0] + AW'(i)] <= push_data_i[i];
      end
    end
  end

endmodule

// File: rtl/oracle_event_tracer.sv
// Producer side of the core-oracle event protocol.
// Packs per-cycle pipeline events (decode/issue/wb/commit/squash) into trace
// records, compacts the valid ones into consecutive FIFO slots and streams
// them out one per valid/ready handshake. The core is never stalled: if a
// cycle's records do not all fit, the whole group is dropped and counted,
// and the count is later emitted in-band as an OVERFLOW record.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   enable_i             : capture enable
//   dec_/iss_/wb_/cmt_/sq_* : pipeline event inputs
//   ev_valid_o/ev_ready_i: output handshake
//   ev_kind_o .. ev_ts_o : head record fields (zero while empty)
//   overflow_o           : a drop is pending and not yet reported
module oracle_event_tracer
  import oracle_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ID_W  = ORACLE_ID_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            dec_valid_i,
  input  logic [ID_W-1:0] dec_id_i,
  input  logic [63:0]     dec_pc_i,
  input  logic [31:0]     dec_inst_i,
  input  logic            dec_is_uop_i,
  input  logic            dec_is_uop_last_i,
  input  logic            iss_valid_i,
  input  logic [ID_W-1:0] iss_id_i,
  input  logic [63:0]     iss_pc_i,
  input  logic [63:0]     iss_rs1_i,
  input  logic [63:0]     iss_rs2_i,
  input  logic            wb_valid_i,
  input  logic [ID_W-1:0] wb_id_i,
  input  logic [63:0]     wb_pc_i,
  input  logic [63:0]     wb_rd_i,
  input  logic            cmt_valid_i,
  input  logic [ID_W-1:0] cmt_id_i,
  input  logic [63:0]     cmt_pc_i,
  input  logic            sq_valid_i,
  input  logic [ID_W-1:0] sq_id_i,
  output logic            ev_valid_o,
  input  logic            ev_ready_i,
  output logic [2:0]      ev_kind_o,
  output logic [ID_W-1:0] ev_id_o,
  output logic [63:0]     ev_pc_o,
  output logic [63:0]     ev_a_o,
  output logic [63:0]     ev_b_o,
  output logic [31:0]     ev_ts_o,
  output logic            overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [31:0]                ts_q, ts_d;
  logic [31:0]                drop_q, drop_d;
  logic                       pending_q, pending_d;

  oracle_ev_t [MAX_PUSH-1:0]  cand_s;     // fixed push order, oldest first
  logic       [MAX_PUSH-1:0]  cand_v_s;
  oracle_ev_t [MAX_PUSH-1:0]  slots_s;    // compacted valid candidates
  logic       [2:0]           idx_s;
  logic       [2:0]           n_s;
  logic       [2:0]           total_s;
  logic       [2:0]           push_cnt_s;
  logic       [AW:0]          free_s;
  logic                       fits_s;

  oracle_ev_t                 head_s;
  logic                       empty_s;
  logic                       full_s;
  logic       [AW:0]          occ_s;
  logic                       valid_s;

  // Build the candidate records in push order: OVERFLOW, COMMIT, WB, ISSUE, DECODE, SQUASH.
  always_comb begin
    cand_s   = '0;
    cand_v_s = {sq_valid_i, dec_valid_i, iss_valid_i, wb_valid_i, cmt_valid_i, pending_q};

    cand_s[0].kind = EV_OVERFLOW;
    cand_s[0].a    = {32'd0, drop_q};
    cand_s[0].ts   = ts_q;

    cand_s[1].kind = EV_COMMIT;
    cand_s[1].id   = ORACLE_ID_W'(cmt_id_i);
    cand_s[1].pc   = cmt_pc_i;
    cand_s[1].ts   = ts_q;

    cand_s[2].kind = EV_WB;
    cand_s[2].id   = ORACLE_ID_W'(wb_id_i);
    cand_s[2].pc   = wb_pc_i;
    cand_s[2].a    = wb_rd_i;
    cand_s[2].ts   = ts_q;

    cand_s[3].kind = EV_ISSUE;
    cand_s[3].id   = ORACLE_ID_W'(iss_id_i);
    cand_s[3].pc   = iss_pc_i;
    cand_s[3].a    = iss_rs1_i;
    cand_s[3].b    = iss_rs2_i;
    cand_s[3].ts   = ts_q;

    cand_s[4].kind = EV_DECODE;
    cand_s[4].id   = ORACLE_ID_W'(dec_id_i);
    cand_s[4].pc   = dec_pc_i;
    cand_s[4].a    = {30'd0, dec_is_uop_last_i, dec_is_uop_i, dec_inst_i};
    cand_s[4].ts   = ts_q;

    cand_s[5].kind = EV_SQUASH;
    cand_s[5].id   = ORACLE_ID_W'(sq_id_i);
    cand_s[5].ts   = ts_q;
  end

  // Compact valid candidates into slots 0..k-1; idx never reaches 6 before the last candidate.
  always_comb begin
    slots_s = '0;
    idx_s   = 3'd0;
    for (int k = 0; k < MAX_PUSH; k++) begin
      slots_s[idx_s] = cand_v_s[k] ? cand_s[k] : slots_s[idx_s];
      idx_s          = idx_s + {2'd0, cand_v_s[k]};
    end
  end

  assign n_s     = {2'd0, cmt_valid_i} + {2'd0, wb_valid_i} + {2'd0, iss_valid_i}
                 + {2'd0, dec_valid_i} + {2'd0, sq_valid_i};
  assign total_s = n_s + {2'd0, pending_q};
  // Room is judged on registered occupancy only; a same-cycle pop gives no credit.
  assign free_s  = full_s ? {(AW+1){1'b0}} : (DEPTH_W - occ_s);
  assign fits_s  = ((AW+1)'(total_s) <= free_s);

  // Accept the whole group atomically or drop it and account for the loss.
  always_comb begin
    push_cnt_s = 3'd0;
    pending_d  = pending_q;
    drop_d     = drop_q;
    if (enable_i && fits_s) begin
      push_cnt_s = total_s;
      pending_d  = 1'b0;
      drop_d     = 32'd0;
    end else if (enable_i) begin
      pending_d  = 1'b1;
      drop_d     = sat_add_drop(drop_q, n_s);
    end else begin
      pending_d  = pending_q;
      drop_d     = drop_q;
    end
  end

  // Free-running timestamp, wraps modulo 2^32.
  always_comb begin
    ts_d = ts_q + 32'd1;
  end

  // Timestamp and overflow accounting registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q      <= 32'd0;
      drop_q    <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      drop_q    <= drop_d;
      pending_q <= pending_d;
    end
  end

  multi_push_fifo #(
    .DEPTH    (DEPTH),
    .T        (oracle_ev_t),
    .MAX_PUSH (MAX_PUSH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_data_i (slots_s),
    .push_cnt_i  (push_cnt_s),
    .pop_i       (ev_ready_i),
    .head_o      (head_s),
    .empty_o     (empty_s),
    .full_o      (full_s),
    .occ_o       (occ_s)
  );

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign valid_s    = !empty_s;
  assign ev_valid_o = valid_s;
  assign ev_kind_o  = valid_s ? head_s.kind : 3'd0;
  assign ev_id_o    = valid_s ? ID_W'(head_s.id) : {ID_W{1'b0}};
  assign ev_pc_o    = valid_s ? head_s.pc : 64'd0;
  assign ev_a_o     = valid_s ? head_s.a  : 64'd0;
  assign ev_b_o     = valid_s ? head_s.b  : 64'd0;
  assign ev_ts_o    = valid_s ? head_s.ts : 32'd0;
  assign overflow_o = pending_q;

endmodule

// File: tb/tb_oracle_event_tracer.sv
// Directed self-checking bench for oracle_event_tracer (DEPTH 16, ID_W 32).
module tb_oracle_event_tracer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        dec_valid, dec_is_uop, dec_is_uop_last;
  logic [31:0] dec_id, dec_inst;
  logic [63:0] dec_pc;
  logic        iss_valid;
  logic [31:0] iss_id;
  logic [63:0] iss_pc, iss_rs1, iss_rs2;
  logic        wb_valid;
  logic [31:0] wb_id;
  logic [63:0] wb_pc, wb_rd;
  logic        cmt_valid;
  logic [31:0] cmt_id;
  logic [63:0] cmt_pc;
  logic        sq_valid;
  logic [31:0] sq_id;
  logic        ev_valid, ev_ready;
  logic [2:0]  ev_kind;
  logic [31:0] ev_id, ev_ts;
  logic [63:0] ev_pc, ev_a, ev_b;
  logic        overflow;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] id;
    logic [63:0] pc;
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] ts;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [31:0] ts_mark;

  oracle_event_tracer #(.DEPTH(16), .ID_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .dec_valid_i(dec_valid), .dec_id_i(dec_id), .dec_pc_i(dec_pc), .dec_inst_i(dec_inst),
    .dec_is_uop_i(dec_is_uop), .dec_is_uop_last_i(dec_is_uop_last),
    .iss_valid_i(iss_valid), .iss_id_i(iss_id), .iss_pc_i(iss_pc),
    .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2),
    .wb_valid_i(wb_valid), .wb_id_i(wb_id), .wb_pc_i(wb_pc), .wb_rd_i(wb_rd),
    .cmt_valid_i(cmt_valid), .cmt_id_i(cmt_id), .cmt_pc_i(cmt_pc),
    .sq_valid_i(sq_valid), .sq_id_i(sq_id),
    .ev_valid_o(ev_valid), .ev_ready_i(ev_ready), .ev_kind_o(ev_kind),
    .ev_id_o(ev_id), .ev_pc_o(ev_pc), .ev_a_o(ev_a), .ev_b_o(ev_b), .ev_ts_o(ev_ts),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_ev();
    dec_valid = 1'b0; iss_valid = 1'b0; wb_valid = 1'b0; cmt_valid = 1'b0; sq_valid = 1'b0;
  endtask

  task automatic exp_push(input logic [2:0] k, input logic [31:0] id, input logic [63:0] pc,
                          input logic [63:0] a, input logic [63:0] b, input logic [31:0] ts);
    exp_t e;
    e.kind = k; e.id = id; e.pc = pc; e.a = a; e.b = b; e.ts = ts;
    exp_q.push_back(e);
  endtask

  task automatic commit(input logic [31:0] id, input logic [63:0] pc);
    cmt_valid = 1'b1; cmt_id = id; cmt_pc = pc;
  endtask

  // Sink model: every accepted record must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rec_kind", {61'd0, ev_kind}, {61'd0, mon_e.kind});
        check("rec_id",   {32'd0, ev_id},   {32'd0, mon_e.id});
        check("rec_pc",   ev_pc, mon_e.pc);
        check("rec_a",    ev_a,  mon_e.a);
        check("rec_b",    ev_b,  mon_e.b);
        check("rec_ts",   {32'd0, ev_ts},   {32'd0, mon_e.ts});
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; ev_ready = 1'b1;
    clear_ev();
    dec_id = 32'd0; dec_pc = 64'd0; dec_inst = 32'd0; dec_is_uop = 1'b0; dec_is_uop_last = 1'b0;
    iss_id = 32'd0; iss_pc = 64'd0; iss_rs1 = 64'd0; iss_rs2 = 64'd0;
    wb_id = 32'd0; wb_pc = 64'd0; wb_rd = 64'd0;
    cmt_id = 32'd0; cmt_pc = 64'd0; sq_id = 32'd0;
    repeat (3) step();
    rst_n = 1'b1;
    cyc = 0;

    // Reset state
    check("rst_valid", {63'd0, ev_valid}, 64'd0);
    check("rst_kind",  {61'd0, ev_kind}, 64'd0);
    check("rst_id",    {32'd0, ev_id}, 64'd0);
    check("rst_a",     ev_a, 64'd0);
    check("rst_ts",    {32'd0, ev_ts}, 64'd0);
    check("rst_ovf",   {63'd0, overflow}, 64'd0);

    // Single decode at ts = 3
    repeat (3) step();
    dec_valid = 1'b1; dec_id = 32'd7; dec_pc = 64'h8000_0000; dec_inst = 32'h0010_0093;
    exp_push(3'd0, 32'd7, 64'h8000_0000, 64'h0000_0000_0010_0093, 64'd0, 32'd3);
    step();
    clear_ev();
    check("dec_valid_t1", {63'd0, ev_valid}, 64'd1);
    step();
    check("dec_valid_t2", {63'd0, ev_valid}, 64'd0);

    // All five events in one cycle
    cmt_valid = 1'b1; cmt_id = 32'h10; cmt_pc = 64'h100;
    wb_valid = 1'b1; wb_id = 32'h11; wb_pc = 64'h110; wb_rd = 64'hAAAA;
    iss_valid = 1'b1; iss_id = 32'h12; iss_pc = 64'h120; iss_rs1 = 64'h1111; iss_rs2 = 64'h2222;
    dec_valid = 1'b1; dec_id = 32'h13; dec_pc = 64'h130; dec_inst = 32'hDEAD_BEEF;
    dec_is_uop = 1'b1; dec_is_uop_last = 1'b1;
    sq_valid = 1'b1; sq_id = 32'h14;
    exp_push(3'd3, 32'h10, 64'h100, 64'd0, 64'd0, cyc);
    exp_push(3'd2, 32'h11, 64'h110, 64'hAAAA, 64'd0, cyc);
    exp_push(3'd1, 32'h12, 64'h120, 64'h1111, 64'h2222, cyc);
    exp_push(3'd0, 32'h13, 64'h130, 64'h0000_0003_DEAD_BEEF, 64'd0, cyc);
    exp_push(3'd4, 32'h14, 64'd0, 64'd0, 64'd0, cyc);
    step();
    clear_ev();
    dec_is_uop = 1'b0; dec_is_uop_last = 1'b0;
    repeat (5) step();
    check("five_drained", {63'd0, ev_valid}, 64'd0);
    check("five_all_seen", 64'(exp_q.size()), 64'd0);

    // Sink stall with a WB record at the head
    ev_ready = 1'b0;
    wb_valid = 1'b1; wb_id = 32'h21; wb_pc = 64'h2000; wb_rd = 64'h1234_5678_9ABC_DEF0;
    ts_mark = cyc;
    step();
    clear_ev();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {63'd0, ev_valid}, 64'd1);
      check("stall_kind",  {61'd0, ev_kind}, 64'd2);
      check("stall_id",    {32'd0, ev_id}, 64'h21);
      check("stall_pc",    ev_pc, 64'h2000);
      check("stall_a",     ev_a, 64'h1234_5678_9ABC_DEF0);
      check("stall_ts",    {32'd0, ev_ts}, {32'd0, ts_mark});
      step();
    end
    ev_ready = 1'b1;
    exp_push(3'd2, 32'h21, 64'h2000, 64'h1234_5678_9ABC_DEF0, 64'd0, ts_mark);
    step();
    check("stall_popped", {63'd0, ev_valid}, 64'd0);

    // Occupancy 13, four events arrive: all dropped, later OVERFLOW a=4
    ev_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      commit(32'h300 + i, 64'h3000 + 64'(4 * i));
      exp_push(3'd3, 32'h300 + i, 64'h3000 + 64'(4 * i), 64'd0, 64'd0, cyc);
      step();
    end
    clear_ev();
    commit(32'h400, 64'h4000);
    wb_valid = 1'b1; wb_id = 32'h401;
    iss_valid = 1'b1; iss_id = 32'h402;
    dec_valid = 1'b1; dec_id = 32'h403;
    check("occ13_ovf_before", {63'd0, overflow}, 64'd0);
    step();
    clear_ev();
    check("occ13_ovf_set", {63'd0, overflow}, 64'd1);
    exp_push(3'd5, 32'd0, 64'd0, 64'd4, 64'd0, cyc);
    step();
    check("occ13_ovf_clear", {63'd0, overflow}, 64'd0);
    check("occ13_head_kind", {61'd0, ev_kind}, 64'd3);
    ev_ready = 1'b1;
    repeat (14) step();
    check("occ13_drained", {63'd0, ev_valid}, 64'd0);
    check("occ13_all_seen", 64'(exp_q.size()), 64'd0);

    // Fill past DEPTH with one commit per cycle, then drain
    ev_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      commit(32'h500 + i, 64'h5000 + 64'(i));
      if (i < 16) exp_push(3'd3, 32'h500 + i, 64'h5000 + 64'(i), 64'd0, 64'd0, cyc);
      step();
    end
    clear_ev();
    check("full_ovf", {63'd0, overflow}, 64'd1);
    check("full_valid", {63'd0, ev_valid}, 64'd1);
    ev_ready = 1'b1;
    step();                       // still full at the check: pop only, no credit
    check("full_ovf_hold", {63'd0, overflow}, 64'd1);
    exp_push(3'd5, 32'd0, 64'd0, 64'd2, 64'd0, cyc);
    step();
    for (int i = 0; i < 3; i++) begin
      commit(32'h600 + i, 64'h6000 + 64'(i));
      exp_push(3'd3, 32'h600 + i, 64'h6000 + 64'(i), 64'd0, 64'd0, cyc);
      step();
    end
    clear_ev();
    repeat (20) step();
    check("full_drained", {63'd0, ev_valid}, 64'd0);
    check("full_all_seen", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with 6 records queued and a drop pending
    ev_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      commit(32'h700 + i, 64'h7000 + 64'(i));
      if (i < 16) exp_push(3'd3, 32'h700 + i, 64'h7000 + 64'(i), 64'd0, 64'd0, cyc);
      step();
    end
    clear_ev();
    enable = 1'b0;
    ev_ready = 1'b1;
    repeat (10) step();
    check("pre_rst_ovf", {63'd0, overflow}, 64'd1);
    check("pre_rst_valid", {63'd0, ev_valid}, 64'd1);
    ev_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, ev_valid}, 64'd0);
    check("async_rst_ovf", {63'd0, overflow}, 64'd0);
    exp_q.delete();
    step();
    enable = 1'b1;
    ev_ready = 1'b1;
    rst_n = 1'b1;
    cyc = 0;
    repeat (4) step();
    commit(32'h800, 64'h8000);
    exp_push(3'd3, 32'h800, 64'h8000, 64'd0, 64'd0, 32'd4);
    step();
    clear_ev();
    check("post_rst_valid", {63'd0, ev_valid}, 64'd1);
    step();
    check("post_rst_drained", {63'd0, ev_valid}, 64'd0);
    check("post_rst_all_seen", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
